// File: rtl/adder_rr_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adder_rr_sched_pkg
// Brief    : Shared defaults, index-width helper and round-robin pick function.
// Revision : 1.0 - initial release
// ============================================================================
package adder_rr_sched_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_LATENCY = 2;
    localparam int DEF_WIDTH   = 32;
    localparam int MAX_REQ     = 8;
    localparam int PICK_W      = 3;

    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int IDX_W = idx_w(DEF_NUM_REQ);

    // First set bit of valid scanning cyclically upward from ptr, over n slots.
    // Scanning k downward lets the smallest cyclic distance win last.
    function automatic logic [PICK_W-1:0] rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input logic [PICK_W-1:0]  ptr,
        input int                 n
    );
        logic [PICK_W:0]   idx;
        logic [PICK_W-1:0] pick;
        pick = ptr;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (k < n) begin
                idx = {1'b0, ptr} + (PICK_W + 1)'(k);
                if (idx >= (PICK_W + 1)'(n)) begin
                    idx = idx - (PICK_W + 1)'(n);
                end
                if (valid[idx[PICK_W-1:0]]) begin
                    pick = idx[PICK_W-1:0];
                end
            end
        end
        return pick;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adder_pipe.sv
`default_nettype none
// ============================================================================
// Module   : adder_pipe
// Brief    : LATENCY-stage registered adder carrying an owner tag and valid bit.
// Revision : 1.0 - initial release
// ============================================================================
module adder_pipe #(
    parameter int WIDTH   = 32,
    parameter int IDX_W   = 2,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [IDX_W-1:0] i_tag,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_tag,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry
);

    logic [LATENCY-1:0] r_vld;
    logic [IDX_W-1:0]   r_tag [LATENCY];
    logic [WIDTH:0]     r_res [LATENCY];
    logic [WIDTH:0]     w_res;

    assign w_res = {1'b0, i_a} + {1'b0, i_b};

    // Stages only load on a valid token, so the last stage holds its result
    // between responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
            for (int s = 0; s < LATENCY; s++) begin
                r_tag[s] <= '0;
                r_res[s] <= '0;
            end
        end else begin
            r_vld[0] <= i_valid;
            if (i_valid) begin
                r_tag[0] <= i_tag;
                r_res[0] <= w_res;
            end
            for (int s = 1; s < LATENCY; s++) begin
                r_vld[s] <= r_vld[s-1];
                if (r_vld[s-1]) begin
                    r_tag[s] <= r_tag[s-1];
                    r_res[s] <= r_res[s-1];
                end
            end
        end
    end

    assign o_valid = r_vld[LATENCY-1];
    assign o_tag   = r_tag[LATENCY-1];
    assign o_sum   = r_res[LATENCY-1][WIDTH-1:0];
    assign o_carry = r_res[LATENCY-1][WIDTH];

endmodule
`default_nettype wire

// File: rtl/adder_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : adder_rr_sched
// Brief    : Round-robin scheduler sharing one pipelined adder among NUM_REQ
//            requesters. ADDER_RR_SCHED_PERF_EN adds issue/conflict counters.
// Revision : 1.0 - initial release
// ============================================================================
module adder_rr_sched
    import adder_rr_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int LATENCY = DEF_LATENCY,
    parameter int WIDTH   = DEF_WIDTH
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic                     rsp_carry
`ifdef ADDER_RR_SCHED_PERF_EN
    ,
    output logic [31:0]              perf_issue_cnt,
    output logic [31:0]              perf_conflict_cnt
`endif
);

    localparam int C_IDX_W = idx_w(NUM_REQ);

    logic [C_IDX_W-1:0] r_ptr;
    logic [C_IDX_W-1:0] w_gnt;
    logic [C_IDX_W-1:0] w_ptr_nxt;
    logic [MAX_REQ-1:0] w_valid_ext;
    logic               w_xfer;
    logic [WIDTH-1:0]   w_a;
    logic [WIDTH-1:0]   w_b;
    logic               w_pipe_vld;
    logic [C_IDX_W-1:0] w_pipe_tag;

    assign w_valid_ext = MAX_REQ'(req_valid);
    assign w_gnt       = C_IDX_W'(rr_pick(w_valid_ext, PICK_W'(r_ptr), NUM_REQ));

    // Ready is suppressed during reset so nothing transfers on a reset edge.
    assign w_xfer    = (|req_valid) & ~wb_rst_i;
    assign req_ready = w_xfer ? (NUM_REQ'(1) << w_gnt) : '0;
    assign w_ptr_nxt = (w_gnt == C_IDX_W'(NUM_REQ - 1)) ? '0 : w_gnt + 1'b1;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ptr <= '0;
        end else if (w_xfer) begin
            r_ptr <= w_ptr_nxt;
        end
    end

    assign w_a = req_a[w_gnt*WIDTH +: WIDTH];
    assign w_b = req_b[w_gnt*WIDTH +: WIDTH];

    adder_pipe #(
        .WIDTH   (WIDTH),
        .IDX_W   (C_IDX_W),
        .LATENCY (LATENCY)
    ) u_pipe (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .i_valid (w_xfer),
        .i_tag   (w_gnt),
        .i_a     (w_a),
        .i_b     (w_b),
        .o_valid (w_pipe_vld),
        .o_tag   (w_pipe_tag),
        .o_sum   (rsp_sum),
        .o_carry (rsp_carry)
    );

    assign rsp_valid = w_pipe_vld ? (NUM_REQ'(1) << w_pipe_tag) : '0;

`ifdef ADDER_RR_SCHED_PERF_EN
    logic [31:0] r_issue_cnt;
    logic [31:0] r_conflict_cnt;
    logic        w_multi;

    // Clearing the lowest set bit leaves something only when two or more are set.
    assign w_multi = |(req_valid & (req_valid - 1'b1));

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_issue_cnt    <= '0;
            r_conflict_cnt <= '0;
        end else begin
            if (w_xfer) begin
                r_issue_cnt <= r_issue_cnt + 32'd1;
            end
            if (w_multi) begin
                r_conflict_cnt <= r_conflict_cnt + 32'd1;
            end
        end
    end

    assign perf_issue_cnt    = r_issue_cnt;
    assign perf_conflict_cnt = r_conflict_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_adder_rr_sched.sv
`default_nettype none
// Self-checking bench for adder_rr_sched: directed scenarios plus randomized
// requesters against a queue-based reference model.
module tb_adder_rr_sched;

    localparam int N = 4;
    localparam int L = 2;
    localparam int W = 32;

    logic           wb_clk_i = 1'b0;
    logic           wb_rst_i;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_sum;
    logic           rsp_carry;
`ifdef ADDER_RR_SCHED_PERF_EN
    logic [31:0]    perf_issue_cnt;
    logic [31:0]    perf_conflict_cnt;
`endif

    adder_rr_sched #(
        .NUM_REQ (N),
        .LATENCY (L),
        .WIDTH   (W)
    ) dut (
        .wb_clk_i          (wb_clk_i),
        .wb_rst_i          (wb_rst_i),
        .req_valid         (req_valid),
        .req_a             (req_a),
        .req_b             (req_b),
        .req_ready         (req_ready),
        .rsp_valid         (rsp_valid),
        .rsp_sum           (rsp_sum),
        .rsp_carry         (rsp_carry)
`ifdef ADDER_RR_SCHED_PERF_EN
        ,
        .perf_issue_cnt    (perf_issue_cnt),
        .perf_conflict_cnt (perf_conflict_cnt)
`endif
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: outstanding responses keyed by the edge they appear after.
    typedef struct {
        int             due;
        int             owner;
        logic [W:0]     res;
    } rsp_t;

    rsp_t        pend[$];
    int          gnt_log[$];
    int          m_ptr;
    int          edge_cnt;
    int          last_g;
    logic [W-1:0] m_sum;
    logic        m_carry;
    logic [31:0] m_issue;
    logic [31:0] m_conf;

    function automatic int model_grant();
        if (wb_rst_i) return -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(0, 3))
            0:       return '1;
            1:       return '0;
            default: return $urandom;
        endcase
    endfunction

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    // One clock: check at the falling edge, advance the model at the rising edge.
    task automatic cycle();
        int         g;
        logic [N-1:0] exp_rdy;
        logic [N-1:0] exp_rv;
        rsp_t       r;
        @(negedge wb_clk_i);
        g = model_grant();
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("req_ready", req_ready, exp_rdy);
        exp_rv = '0;
        if (pend.size() > 0 && pend[0].due == edge_cnt) begin
            r = pend.pop_front();
            exp_rv[r.owner] = 1'b1;
            m_sum   = r.res[W-1:0];
            m_carry = r.res[W];
        end
        check("rsp_valid", rsp_valid, exp_rv);
        check("rsp_sum", rsp_sum, m_sum);
        check("rsp_carry", rsp_carry, m_carry);
`ifdef ADDER_RR_SCHED_PERF_EN
        check("perf_issue", perf_issue_cnt, m_issue);
        check("perf_conflict", perf_conflict_cnt, m_conf);
`endif
        @(posedge wb_clk_i);
        edge_cnt++;
        last_g = -1;
        if (wb_rst_i) begin
            pend.delete();
            m_ptr   = 0;
            m_sum   = '0;
            m_carry = 1'b0;
            m_issue = '0;
            m_conf  = '0;
        end else begin
            if (g >= 0) begin
                r.due   = edge_cnt + L - 1;
                r.owner = g;
                r.res   = {1'b0, req_a[g*W +: W]} + {1'b0, req_b[g*W +: W]};
                pend.push_back(r);
                m_ptr = (g + 1) % N;
                m_issue++;
                gnt_log.push_back(g);
                last_g = g;
            end
            if ($countones(req_valid) >= 2) m_conf++;
        end
        #1;
    endtask

    task automatic idle(input int n);
        req_valid = '0;
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic reset_cycle();
        req_valid = '0;
        wb_rst_i  = 1'b1;
        cycle();
        wb_rst_i  = 1'b0;
    endtask

    initial begin
        int cnt02;
        wb_rst_i  = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        repeat (2) @(posedge wb_clk_i);
        #1;
        pend.delete();
        m_ptr = 0; edge_cnt = 0; last_g = -1;
        m_sum = '0; m_carry = 1'b0; m_issue = '0; m_conf = '0;

        // Reset state, then single request from requester 1
        cycle();
        wb_rst_i = 1'b0;
        req_valid = 4'b0010;
        set_op(1, 32'h0000_0005, 32'h0000_0007);
        cycle();
        req_valid = '0;
        cycle();
        check("t1_rsp_valid", rsp_valid, 4'b0010);
        check("t1_rsp_sum", rsp_sum, 32'h0000_000C);
        check("t1_rsp_carry", rsp_carry, 1'b0);
        idle(2);
        check("t1_hold_sum", rsp_sum, 32'h0000_000C);

        // Carry-out and wrap
        req_valid = 4'b0001;
        set_op(0, 32'hFFFF_FFFF, 32'h0000_0001);
        cycle();
        req_valid = '0;
        cycle();
        check("t2_rsp_valid", rsp_valid, 4'b0001);
        check("t2_rsp_sum", rsp_sum, 32'h0000_0000);
        check("t2_rsp_carry", rsp_carry, 1'b1);
        idle(2);

        // All four contending from ptr=0
        reset_cycle();
        gnt_log.delete();
        for (int i = 0; i < N; i++) set_op(i, rnd_op(), rnd_op());
        req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            cycle();
            if (last_g >= 0) set_op(last_g, rnd_op(), rnd_op());
        end
        idle(L + 1);
        check("rr_order_len", gnt_log.size(), 8);
        for (int k = 0; k < gnt_log.size() && k < 8; k++) check("rr_order", gnt_log[k], k % 4);

        // Sparse fairness with ptr=2
        gnt_log.delete();
        req_valid = 4'b0010;
        set_op(1, 32'd100, 32'd200);
        cycle();
        req_valid = 4'b1010;
        set_op(1, 32'd11, 32'd22);
        set_op(3, 32'd33, 32'd44);
        for (int k = 0; k < 3; k++) cycle();
        idle(L + 1);
        check("sparse_len", gnt_log.size(), 4);
        if (gnt_log.size() == 4) begin
            check("sparse_g1", gnt_log[1], 3);
            check("sparse_g2", gnt_log[2], 1);
            check("sparse_g3", gnt_log[3], 3);
        end
        cnt02 = 0;
        foreach (gnt_log[k]) if (gnt_log[k] == 0 || gnt_log[k] == 2) cnt02++;
        check("sparse_no02", cnt02, 0);

        // Reset mid-operation drops in-flight work
        req_valid = 4'b0001;
        set_op(0, 32'd1, 32'd2);
        cycle();
        req_valid = 4'b0010;
        set_op(1, 32'd3, 32'd4);
        cycle();
        reset_cycle();
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("rst_drop", rsp_valid, 4'b0000);
        end
        gnt_log.delete();
        req_valid = 4'b0100;
        set_op(2, 32'h0000_1234, 32'h0000_4321);
        cycle();
        req_valid = '0;
        cycle();
        check("post_rst_gnt", (gnt_log.size() == 1) ? gnt_log[0] : -1, 2);
        check("post_rst_valid", rsp_valid, 4'b0100);
        check("post_rst_sum", rsp_sum, 32'h0000_5555);
        idle(2);

`ifdef ADDER_RR_SCHED_PERF_EN
        begin
            logic [N-1:0] pat [10];
            pat = '{4'b0011, 4'b0010, 4'b1100, 4'b1000, 4'b0011,
                    4'b0010, 4'b0101, 4'b0001, 4'b0001, 4'b0100};
            reset_cycle();
            check("perf_issue_rst", perf_issue_cnt, 32'd0);
            check("perf_conflict_rst", perf_conflict_cnt, 32'd0);
            for (int i = 0; i < N; i++) set_op(i, rnd_op(), rnd_op());
            for (int k = 0; k < 10; k++) begin
                req_valid = pat[k];
                cycle();
            end
            check("perf_issue_10", perf_issue_cnt, 32'd10);
            check("perf_conflict_4", perf_conflict_cnt, 32'd4);
            idle(L + 1);
        end
`endif

        // Randomized requesters with occasional reset
        for (int c = 0; c < 1500; c++) begin
            wb_rst_i = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && i != last_g) begin
                    if ($urandom_range(0, 9) == 0) req_valid[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    req_valid[i] = 1'b1;
                    set_op(i, rnd_op(), rnd_op());
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
            cycle();
        end
        wb_rst_i = 1'b0;
        idle(L + 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
